// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_pkg                                                    |
// | Description : Shared constants and encodings for the pipeline front end:  |
// |               NOP encoding, default reset PC, PC source and result source |
// |               select encodings.                                           |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
package riscv_pkg;

    // addi x0, x0, 0 - the canonical bubble
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Next-PC select driven from execute; 2'b11 is reserved and behaves as
    // PCSRC_TARGET.
    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_ALU    = 2'b10
    } pcsrc_t;

    // Result select of the instruction in execute; RES_MEM marks a load.
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } resultsrc_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_detect                                                |
// | Description : Combinational load-use and redirect detection producing     |
// |               stall/flush controls for the F, D and E stages.             |
// | Ports       : i_pcsrc_e      - next-PC select from execute                |
// |               i_result_src_e - result select of the instruction in E      |
// |               i_rd_e         - destination register of the instr in E     |
// |               i_valid_d      - F/D holds a real instruction               |
// |               i_rs1_d/i_rs2_d- source registers of the instr in D         |
// |               o_redirect     - execute is steering the PC                 |
// |               o_stall_f/d    - hold PC / hold F/D register                |
// |               o_flush_d/e    - squash F/D / insert bubble into D/E        |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module hazard_detect
    import riscv_pkg::*;
(
    input  logic [1:0] i_pcsrc_e,
    input  logic [1:0] i_result_src_e,
    input  logic [4:0] i_rd_e,
    input  logic       i_valid_d,
    input  logic [4:0] i_rs1_d,
    input  logic [4:0] i_rs2_d,
    output logic       o_redirect,
    output logic       o_stall_f,
    output logic       o_stall_d,
    output logic       o_flush_d,
    output logic       o_flush_e
);

    logic w_load_use;

    assign o_redirect = (i_pcsrc_e != 2'b00);

    // A load writing x0 never creates a dependency, and a bubble in D has no
    // real sources even though its fields decode to x0.
    assign w_load_use = (i_result_src_e == RES_MEM)
                      & (i_rd_e != 5'd0)
                      & i_valid_d
                      & ((i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d));

    // A redirect squashes the instruction in D, so any load-use it would
    // have suffered is moot: no stall when both fire together.
    assign o_stall_f = w_load_use & ~o_redirect;
    assign o_stall_d = w_load_use & ~o_redirect;
    assign o_flush_d = o_redirect;
    assign o_flush_e = o_redirect | w_load_use;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_stage                                                  |
// | Description : Pipeline front end. Holds the PC, drives instruction memory,|
// |               registers the F/D stage, decodes register fields, resolves  |
// |               load-use stalls and execute redirects, and keeps saturating |
// |               stall/flush event counters.                                 |
// | Ports       : clk, rst (sync, active high)                                |
// |               PCSrcE_i/PCTargetE_i/ALUResultE_i - redirect from execute   |
// |               ResultSrcE_i/RdE_i - load detection in execute              |
// |               imem_addr_o/imem_data_i - combinational instruction memory  |
// |               PCF_o, InstrD_o, PCD_o, PCPlus4D_o, ValidD_o - F/D state    |
// |               Rs1D_o/Rs2D_o/RdD_o - decoded register fields               |
// |               StallF_o/StallD_o/FlushE_o - hazard controls                |
// |               stall_cnt_o/flush_cnt_o - saturating event counters         |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            PCSrcE_i,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    input  logic [DATA_WIDTH-1:0] ALUResultE_i,
    input  logic [1:0]            ResultSrcE_i,
    input  logic [4:0]            RdE_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    output logic [DATA_WIDTH-1:0] PCF_o,
    output logic [DATA_WIDTH-1:0] InstrD_o,
    output logic [DATA_WIDTH-1:0] PCD_o,
    output logic [DATA_WIDTH-1:0] PCPlus4D_o,
    output logic                  ValidD_o,
    output logic [4:0]            Rs1D_o,
    output logic [4:0]            Rs2D_o,
    output logic [4:0]            RdD_o,
    output logic                  StallF_o,
    output logic                  StallD_o,
    output logic                  FlushE_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

    localparam logic [DATA_WIDTH-1:0] c_nop      = DATA_WIDTH'(NOP_INSTR);
    localparam logic [DATA_WIDTH-1:0] c_pc_step  = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] c_align_mk = ~DATA_WIDTH'(3);

    logic [DATA_WIDTH-1:0] r_pc_f;
    logic [DATA_WIDTH-1:0] r_instr_d;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic [DATA_WIDTH-1:0] r_pc_plus4_d;
    logic                  r_valid_d;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic [CNT_WIDTH-1:0]  r_flush_cnt;

    logic [DATA_WIDTH-1:0] w_pc_plus4_f;
    logic [DATA_WIDTH-1:0] w_target;
    logic [DATA_WIDTH-1:0] w_target_aligned;
    logic                  w_redirect;
    logic                  w_stall_f;
    logic                  w_stall_d;
    logic                  w_flush_d;
    logic                  w_flush_e;

    assign w_pc_plus4_f = r_pc_f + c_pc_step;

    // Only the JALR encoding selects the ALU result; the reserved encoding
    // falls through to the branch/JAL target.
    assign w_target         = (PCSrcE_i == PCSRC_ALU) ? ALUResultE_i : PCTargetE_i;
    assign w_target_aligned = w_target & c_align_mk;

    hazard_detect u_hazard_detect (
        .i_pcsrc_e      (PCSrcE_i),
        .i_result_src_e (ResultSrcE_i),
        .i_rd_e         (RdE_i),
        .i_valid_d      (r_valid_d),
        .i_rs1_d        (r_instr_d[19:15]),
        .i_rs2_d        (r_instr_d[24:20]),
        .o_redirect     (w_redirect),
        .o_stall_f      (w_stall_f),
        .o_stall_d      (w_stall_d),
        .o_flush_d      (w_flush_d),
        .o_flush_e      (w_flush_e)
    );

    // Program counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f <= RESET_PC;
        end else if (w_redirect) begin
            r_pc_f <= w_target_aligned;
        end else if (!w_stall_f) begin
            r_pc_f <= w_pc_plus4_f;
        end
    end

    // F/D pipeline register; PCD/PCPlus4D are left untouched on a flush
    // since nothing downstream consumes them for a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_d    <= c_nop;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (w_flush_d) begin
            r_instr_d    <= c_nop;
            r_valid_d    <= 1'b0;
        end else if (!w_stall_d) begin
            r_instr_d    <= imem_data_i;
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_plus4_f;
            r_valid_d    <= 1'b1;
        end
    end

    // Saturating debug counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_f && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign imem_addr_o = r_pc_f;
    assign PCF_o       = r_pc_f;
    assign InstrD_o    = r_instr_d;
    assign PCD_o       = r_pc_d;
    assign PCPlus4D_o  = r_pc_plus4_d;
    assign ValidD_o    = r_valid_d;
    assign Rs1D_o      = r_instr_d[19:15];
    assign Rs2D_o      = r_instr_d[24:20];
    assign RdD_o       = r_instr_d[11:7];
    assign StallF_o    = w_stall_f;
    assign StallD_o    = w_stall_d;
    assign FlushE_o    = w_flush_e;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_stage                                               |
// | Description : Self-checking bench for fetch_stage: directed stimulus, a   |
// |               cycle-level reference model and literal spot checks.        |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [31:0] c_nop     = 32'h0000_0013;
    localparam logic [31:0] c_add_x6  = 32'h0072_8333; // add x6, x5, x7
    localparam logic [31:0] c_rst_pc  = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsrc_e;
    logic [31:0] pc_target_e;
    logic [31:0] alu_result_e;
    logic [1:0]  result_src_e;
    logic [4:0]  rd_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d;
    logic [4:0]  rs1_d, rs2_d, rdd;
    logic        stall_f, stall_d, flush_e;
    logic [15:0] stall_cnt, flush_cnt;

    // Instruction memory returns its own address unless a specific word is forced
    logic        imem_force;
    logic [31:0] imem_val;
    assign imem_data = imem_force ? imem_val : imem_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .PCSrcE_i     (pcsrc_e),
        .PCTargetE_i  (pc_target_e),
        .ALUResultE_i (alu_result_e),
        .ResultSrcE_i (result_src_e),
        .RdE_i        (rd_e),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .PCF_o        (pc_f),
        .InstrD_o     (instr_d),
        .PCD_o        (pc_d),
        .PCPlus4D_o   (pc_plus4_d),
        .ValidD_o     (valid_d),
        .Rs1D_o       (rs1_d),
        .Rs2D_o       (rs2_d),
        .RdD_o        (rdd),
        .StallF_o     (stall_f),
        .StallD_o     (stall_d),
        .FlushE_o     (flush_e),
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
    logic        m_valid;
    int unsigned m_stalls, m_flushes;
    bit          m_live = 1'b0;

    function automatic bit model_lu();
        logic [31:0] ins;
        ins = m_instr;
        return (result_src_e == 2'b01) && (rd_e != 5'd0) && m_valid &&
               ((rd_e == ins[19:15]) || (rd_e == ins[24:20]));
    endfunction

    always @(posedge clk) begin
        bit          redir, stall;
        logic [31:0] word, old_pc, tgt;
        if (rst) begin
            m_pc = c_rst_pc; m_instr = c_nop; m_pcd = 0; m_pc4d = 0; m_valid = 0;
            m_stalls = 0; m_flushes = 0; m_live = 1'b1;
        end else if (m_live) begin
            redir  = (pcsrc_e != 2'b00);
            stall  = model_lu() && !redir;
            word   = imem_force ? imem_val : m_pc;
            old_pc = m_pc;
            if (stall && m_stalls < 16'hFFFF) m_stalls++;
            if (redir && m_flushes < 16'hFFFF) m_flushes++;
            tgt = (pcsrc_e == 2'b10) ? alu_result_e : pc_target_e;
            if (redir)       m_pc = {tgt[31:2], 2'b00};
            else if (!stall) m_pc = old_pc + 32'd4;
            if (redir) begin
                m_instr = c_nop; m_valid = 0;
            end else if (!stall) begin
                m_instr = word; m_pcd = old_pc; m_pc4d = old_pc + 32'd4; m_valid = 1;
            end
        end
    end

    // Compare on the falling edge, away from state updates and input changes
    always @(negedge clk) begin
        bit redir, lu;
        logic [31:0] ins;
        if (m_live) begin
            redir = (pcsrc_e != 2'b00);
            lu    = model_lu();
            ins   = m_instr;
            check("PCF",       pc_f,       m_pc);
            check("imem_addr", imem_addr,  m_pc);
            check("InstrD",    instr_d,    m_instr);
            check("PCD",       pc_d,       m_pcd);
            check("PCPlus4D",  pc_plus4_d, m_pc4d);
            check("ValidD",    32'(valid_d), 32'(m_valid));
            check("Rs1D",      32'(rs1_d), 32'(ins[19:15]));
            check("Rs2D",      32'(rs2_d), 32'(ins[24:20]));
            check("RdD",       32'(rdd),   32'(ins[11:7]));
            check("StallF",    32'(stall_f), 32'(lu && !redir));
            check("StallD",    32'(stall_d), 32'(lu && !redir));
            check("FlushE",    32'(flush_e), 32'(lu || redir));
            check("stall_cnt", 32'(stall_cnt), m_stalls);
            check("flush_cnt", 32'(flush_cnt), m_flushes);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_hazards();
        pcsrc_e = 2'b00; result_src_e = 2'b00; rd_e = 5'd0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; imem_force = 1'b0; imem_val = 32'h0;
        pc_target_e = 32'h0; alu_result_e = 32'h0;
        clear_hazards();
        tick(); tick();
        check("rst PCF",       pc_f, c_rst_pc);
        check("rst InstrD",    instr_d, c_nop);
        check("rst ValidD",    32'(valid_d), 32'd0);
        check("rst stall_cnt", 32'(stall_cnt), 32'd0);

        // Sequential fetch
        rst = 1'b0;
        tick();
        check("seq PCF1",    pc_f, 32'hBFC0_0004);
        check("seq InstrD1", instr_d, 32'hBFC0_0000);
        check("seq PCD1",    pc_d, 32'hBFC0_0000);
        check("seq P4D1",    pc_plus4_d, 32'hBFC0_0004);
        check("seq ValidD1", 32'(valid_d), 32'd1);
        tick();
        check("seq PCF2",    pc_f, 32'hBFC0_0008);

        // Branch redirect with misaligned target
        pcsrc_e = 2'b01; pc_target_e = 32'hBFC0_0103;
        #1 check("br FlushE", 32'(flush_e), 32'd1);
        tick();
        clear_hazards();
        check("br PCF",       pc_f, 32'hBFC0_0100);
        check("br InstrD",    instr_d, c_nop);
        check("br ValidD",    32'(valid_d), 32'd0);
        check("br flush_cnt", 32'(flush_cnt), 32'd1);
        tick();
        check("br InstrD2",   instr_d, 32'hBFC0_0100);

        // Load-use on rs1
        imem_force = 1'b1; imem_val = c_add_x6;
        tick();
        imem_force = 1'b0;
        check("lu InstrD", instr_d, c_add_x6);
        result_src_e = 2'b01; rd_e = 5'd5;
        #1 check("lu StallF", 32'(stall_f), 32'd1);
        tick();
        check("lu PCF hold",  pc_f, 32'hBFC0_0108);
        check("lu InstrD hold", instr_d, c_add_x6);
        check("lu stall_cnt", 32'(stall_cnt), 32'd1);
        clear_hazards();
        tick();
        check("lu PCF adv",   pc_f, 32'hBFC0_010C);
        check("lu InstrD adv", instr_d, 32'hBFC0_0108);

        // Load to x0: no stall
        imem_force = 1'b1;
        tick();
        imem_force = 1'b0;
        result_src_e = 2'b01; rd_e = 5'd0;
        #1 check("x0 StallF", 32'(stall_f), 32'd0);
        tick();
        clear_hazards();
        check("x0 PCF", pc_f, 32'hBFC0_0114);

        // Load-use together with JALR: redirect wins
        imem_force = 1'b1;
        tick();
        imem_force = 1'b0;
        result_src_e = 2'b01; rd_e = 5'd5; pcsrc_e = 2'b10; alu_result_e = 32'h0000_0040;
        #1 check("both StallF", 32'(stall_f), 32'd0);
        check("both FlushE", 32'(flush_e), 32'd1);
        tick();
        clear_hazards();
        check("both PCF",       pc_f, 32'h0000_0040);
        check("both ValidD",    32'(valid_d), 32'd0);
        check("both stall_cnt", 32'(stall_cnt), 32'd1);

        // PC wrap
        pcsrc_e = 2'b11; pc_target_e = 32'hFFFF_FFFE;
        tick();
        clear_hazards();
        check("wrap PCF top", pc_f, 32'hFFFF_FFFC);
        tick();
        check("wrap PCF zero", pc_f, 32'h0000_0000);

        // Long stall to saturate the counter (rs2 match)
        imem_force = 1'b1;
        tick();
        imem_force = 1'b0;
        result_src_e = 2'b01; rd_e = 5'd7;
        repeat (65536 + 3) tick();
        check("sat stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
        check("sat StallF",    32'(stall_f), 32'd1);

        // Reset in the middle of the stall
        rst = 1'b1;
        tick();
        check("mrst PCF",       pc_f, c_rst_pc);
        check("mrst stall_cnt", 32'(stall_cnt), 32'd0);
        check("mrst flush_cnt", 32'(flush_cnt), 32'd0);
        rst = 1'b0;
        clear_hazards();
        tick(); tick();
        check("post PCF", pc_f, 32'hBFC0_0008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipeline front end, directly upstream of the decode/execute datapath.
- Holds the program counter and drives the instruction-memory address.
- Registers the fetched instruction into the F/D pipeline register, and extracts Rs1D/Rs2D/RdD for the downstream stages.
- Integrates load-use hazard detection and branch/jump redirect: generates stall and flush for F, D and E, plus saturating stall/flush event counters for debug.

Parameters:
- DATA_WIDTH, 32, datapath and PC width.
- RESET_PC, 32'hBFC00000, PC value after reset.
- CNT_WIDTH, 16, width of the stall/flush event counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- PCSrcE_i  input  2  redirect select from execute: 00 = PC+4, 01 = PCTargetE (branch/JAL), 10 = ALUResultE (JALR), 11 = reserved.
- PCTargetE_i  input  DATA_WIDTH  branch/JAL target from execute.
- ALUResultE_i  input  DATA_WIDTH  JALR target from execute.
- ResultSrcE_i  input  2  result select of the instruction in E; 01 = load.
- RdE_i  input  5  destination register of the instruction in E.
- imem_addr_o  output  DATA_WIDTH  instruction-memory address (equals PCF).
- imem_data_i  input  DATA_WIDTH  instruction word; combinational read of imem_addr_o.
- PCF_o  output  DATA_WIDTH  current fetch PC.
- InstrD_o  output  DATA_WIDTH  F/D instruction.
- PCD_o  output  DATA_WIDTH  F/D PC.
- PCPlus4D_o  output  DATA_WIDTH  F/D PC+4.
- ValidD_o  output  1  F/D holds a real instruction, not a bubble.
- Rs1D_o, Rs2D_o, RdD_o  output  5 each  InstrD[19:15], [24:20], [11:7].
- StallF_o, StallD_o  output  1 each  hold PC / hold F/D.
- FlushE_o  output  1  insert a bubble into the D/E register.
- stall_cnt_o, flush_cnt_o  output  CNT_WIDTH each  saturating event counters.

Behaviour:
- Reset (rst=1 at an edge), overriding all other events:
  - PCF = RESET_PC.
  - InstrD = NOP 32'h00000013; PCD = 0; PCPlus4D = 0; ValidD = 0.
  - Both counters = 0.
  - Reset asserted mid-stall or mid-redirect discards the pending event.
- Redirect (combinational): redirect = (PCSrcE_i != 00). Reserved 11 is treated as 01.
- Load-use (combinational): lu = (ResultSrcE_i == 01) & (RdE_i != 0) & ValidD & ((RdE_i == Rs1D) | (RdE_i == Rs2D)).
- Hazard outputs:
  - StallF = StallD = lu & ~redirect.
  - FlushE = redirect | lu.
  - FlushD = redirect (internal).
- PC next-state priority, highest first:
  - redirect: PCF <= target, with target[1:0] forced to 00. Target is PCTargetE_i, or ALUResultE_i for 10.
  - StallF: PCF holds.
  - otherwise: PCF <= PCF + 4, with 32-bit wrap (FFFFFFFC -> 00000000).
- F/D register next-state priority, highest first:
  - FlushD: InstrD <= NOP, ValidD <= 0; PCD and PCPlus4D are don't-care and are held.
  - StallD: all fields hold.
  - otherwise: InstrD <= imem_data_i, PCD <= PCF, PCPlus4D <= PCF+4, ValidD <= 1.
- Simultaneous redirect and load-use: redirect wins. The stalled instruction is on the wrong path and is squashed, so there is no stall.
- Latency:
  - Instruction fetched at PCF appears on InstrD_o one cycle later.
  - A redirect seen at cycle N gives PCF = target at N+1 and the target instruction in D at N+2.
  - Branch penalty is 2 bubbles.
- Load-use gives exactly one stall cycle for the same D instruction. On the next cycle the load has left E, so lu deasserts.
- Counters:
  - stall_cnt increments on each cycle with StallF=1.
  - flush_cnt increments on each cycle with redirect=1.
  - Both saturate at all-ones with no wrap.
- Rs1D/Rs2D/RdD are pure slices of registered InstrD, so they are glitch-free. A bubble decodes to Rs1=0, Rs2=0, Rd=0.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR = 32'h00000013; RESET_PC default.
  - pcsrc_t enum (PCSRC_PLUS4, PCSRC_TARGET, PCSRC_ALU).
  - resultsrc_t enum (RES_ALU, RES_MEM, RES_PC4).
- One sub-module, hazard_detect: combinational lu / redirect -> StallF, StallD, FlushD, FlushE. The same block will later host forwarding selects.
- PC register, F/D register and counters stay in fetch_stage.

Test Plan:
- Reset release, imem returns addr-indexed words, no hazards -> PCF sequence BFC00000, BFC00004, BFC00008. InstrD lags by one cycle; ValidD=1 from the second edge.
- PCSrcE_i=01, PCTargetE_i=BFC00103 for one cycle -> next PCF=BFC00100. InstrD=NOP and ValidD=0 for one cycle. FlushE=1 that cycle; flush_cnt=1.
- Load in E (ResultSrcE=01, RdE=5) while InstrD is add x6,x5,x7 -> one cycle with StallF=StallD=FlushE=1. PCF and InstrD hold. Next cycle (RdE=0) pipeline advances; stall_cnt=1.
- Same load-use condition with RdE=0 -> no stall.
- Load-use and PCSrcE=10 (ALUResultE=00000040) in the same cycle -> no stall. PCF=00000040, D flushed, FlushE=1, stall_cnt unchanged.
- Force PCF=FFFFFFFC via redirect, then no hazard -> PCF wraps to 00000000.
- Hold a stall for 2^16+3 cycles -> stall_cnt saturates at FFFF.
- Assert rst during a stall -> PCF=BFC00000 and counters=0 on the next edge.
